// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, access sizes and funct3 codes for the load/store sequencer.
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign- or zero-extends the assembled load bytes to XLEN.
module lsu_load_ext import lsu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] acc,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] rdata
);
    always_comb begin
        rdata = (size == SZ_B) ? {{(XLEN-8){acc[7] & ~uns}}, acc[7:0]} :
                (size == SZ_H) ? {{(XLEN-16){acc[15] & ~uns}}, acc[15:0]} : acc;
    end
endmodule

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: splits one RISC-V load/store into 1, 2 or 4 byte accesses
// on an 8-bit data memory and returns the extended load result.
module lsu_byte_seq import lsu_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_wd,
    output logic              mem_we,
    input  logic [7:0]        mem_rd
);
    lsu_state_t        state_q, state_d;
    logic              we_q, we_d, err_q, err_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, acc_q, acc_d, ext;
    logic [1:0]        idx_q, idx_d, last_idx;
    logic              illegal;

    // Last byte index is N-1: 0, 1 or 3 for byte, half, word.
    assign last_idx = {f3_q[1], f3_q[1] | f3_q[0]};
    assign illegal  = (&req_funct3[1:0]) | (req_we & req_funct3[2]);

    lsu_load_ext #(.XLEN(XLEN)) u_ext (
        .acc   (acc_q),
        .size  (f3_q[1:0]),
        .uns   (f3_q[2]),
        .rdata (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_a      = addr_q;
        mem_wd     = '0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = illegal;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_a  = addr_q + ADDR_W'(idx_q);
                mem_we = we_q & ~rst;
                mem_wd = we_q ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
                if (!we_q) acc_d[{idx_q, 3'b000} +: 8] = mem_rd;
                idx_d = idx_q + 2'd1;
                if (idx_q == last_idx) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q | err_q) ? '0 : ext;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer between the pipeline MEM stage and the 8-bit, 256-entry data memory. It accepts one 32-bit RISC-V load or store (LB/LH/LW/LBU/LHU/SB/SH/SW), splits it into 1, 2 or 4 single-byte memory accesses, and returns the sign- or zero-extended load result. It drives the memory's address, write-data and write-enable pins, and consumes its combinational read data. It is the initiator side of the data-memory interface.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; matches memory depth 2^ADDR_W.
- XLEN, 32, register/data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: [1:0] is size (0 = byte, 1 = half, 2 = word, 3 = illegal); [2] selects unsigned for loads.
- req_addr  in  ADDR_W  byte address; any alignment allowed.
- req_wdata  in  XLEN  store data; low bytes are used.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3.
- mem_a  out  ADDR_W  memory byte address.
- mem_wd  out  8  memory write byte.
- mem_we  out  1  memory write enable.
- mem_rd  in  8  memory read byte; combinational in mem_a.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - req_ready = 1.
  - On handshake, latch we, funct3, addr, wdata; clear idx and the data accumulator.
  - Set N = 1, 2 or 4 from funct3[1:0].
  - Illegal requests go to RESP with err = 1. Illegal means funct3[1:0] = 3, or a store with funct3[2] = 1.
  - Legal requests go to ACCESS.
- **ACCESS**, one byte per cycle:
  - mem_a = addr + idx, modulo 2^ADDR_W, so addresses wrap from 0xFF to 0x00.
  - Store: mem_we = 1, mem_wd = wdata[8*idx+7 : 8*idx].
  - Load: mem_we = 0, and mem_rd is captured into accumulator byte idx at the clock edge.
  - Little-endian: byte 0 is at the lowest address.
  - idx increments each cycle; after idx = N-1, go to RESP.
- **RESP**
  - resp_valid = 1.
  - resp_rdata: for a byte load, sign-extend bit 7 (LB) or zero-extend (LBU). For a half load, sign-extend bit 15 (LH) or zero-extend (LHU). LW returns the full word.
  - resp_rdata = 0 for stores and errors.
  - Hold all response outputs stable until resp_ready = 1, then go to IDLE.
- Outside ACCESS: mem_we = 0, mem_a = latched addr, mem_wd = 0.
- mem_we is gated by !rst, so no write commits on a reset cycle.
- Only one request is in flight; req_ready = 0 in ACCESS and RESP.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_a 0, mem_wd 0, idx 0.
- Request accepted at edge T, legal request:
  - Byte accesses in cycles T+1 … T+N.
  - resp_valid rises in cycle T+N+1.
  - Latency N+1 cycles: 2 for byte, 3 for half, 4 for word.
- Illegal request accepted at edge T: resp_valid in cycle T+1, no memory access.
- Response handshake at edge R: req_ready = 1 in cycle R+1. There is no IDLE bypass, so the minimum spacing between accepts is N+2 cycles.
- Reset mid-operation:
  - The FSM returns to IDLE at the next edge.
  - Bytes already written stay written; the remaining bytes are never issued.
  - No response is produced.
- Simultaneous rst and req_valid: reset wins and the request is not accepted.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_t {IDLE, ACCESS, RESP};
  - size constants SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
- One combinational sub-module, lsu_load_ext: inputs are the accumulator, size and unsigned flag; output is resp_rdata.
- The FSM, index counter and byte lanes live in lsu_byte_seq.

## Test plan
- **SW, no backpressure.** SW 0xDEADBEEF at 0x10 with resp_ready = 1.
  - mem_we pulses at 0x10 = EF, 0x11 = BE, 0x12 = AD, 0x13 = DE on four consecutive cycles.
  - resp_valid appears 5 cycles after accept, with resp_rdata = 0.
- **Byte loads after the SW.**
  - LB 0x13 returns 0xFFFFFFDE.
  - LBU 0x13 returns 0x000000DE.
  - LH 0x12 returns 0xFFFFDEAD.
  - LHU 0x10 returns 0x0000BEEF.
  - LW 0x10 returns 0xDEADBEEF.
- **Address wrap.**
  - SH 0xA55A at 0xFF writes 0xFF = 5A then 0x00 = A5.
  - LW 0xFE after it reads bytes 0xFE, 0xFF, 0x00, 0x01 in that order.
- **Illegal funct3.** funct3 = 3 load, and funct3 = 4 store.
  - resp_err = 1 and resp_rdata = 0 in the cycle after accept.
  - mem_we is never asserted.
- **Backpressure.** resp_ready held low 3 cycles during an LW response.
  - resp_valid, resp_rdata and resp_err stay stable throughout.
  - req_ready stays 0 until the cycle after the handshake.
  - A second req_valid during this window is not accepted.
- **Reset mid-store.** rst asserted in the third ACCESS cycle of an SW.
  - Exactly 2 mem_we pulses occur.
  - The FSM is back in IDLE at the next edge, with req_ready = 1 and resp_valid = 0.
